fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and runs a single-outstanding-request handshake to instruction memory. It buffers one fetched instruction, and presents `ins_out`/`pc_4_out` to the IF/ID `ins_in`/`pc_4_in` inputs. It honours hazard-unit stalls (`pc_write`) and ID-stage branch/jump redirects, and it supplies a NOP (32'h0) whenever no valid instruction is available.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc_write` in 1: 1 allows the buffered instruction to be consumed by IF/ID this cycle; driven by the hazard unit, same signal as IF/ID `if_id_write`.
- `redirect` in 1: taken branch/jump resolved in ID; asserted in the same cycle as IF/ID `if_flush`.
- `redirect_pc` in 32: redirect target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word-aligned.
- `imem_ack` in 1: request complete, `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `ins_out` out 32: buffered instruction to IF/ID; 32'h0 whenever `ins_valid`=0.
- `pc_4_out` out 32: address of `ins_out` + 4.
- `ins_valid` out 1: `ins_out` holds a real instruction.
- `fetch_fault` out 1: sticky misaligned-redirect flag; tied 0 unless `FETCH_MISALIGN_TRAP_EN` is defined.

## Operation
- Registers:
  - `pc`: next address to issue.
  - `req_addr`: address of the outstanding request.
  - Output buffer: `ins_out`, `pc_4_out`, `ins_valid`.
  - State.
- States:
  - FETCH: no request outstanding.
  - WAIT: request issued, awaiting ack.
  - DROP: a request is outstanding whose data must be discarded.
  - FAULT: only with the macro.
- Consume: the buffer is consumed at an edge when `ins_valid`=1 and `pc_write`=1. With no new ack that edge, the buffer becomes `ins_valid`=0 and `ins_out`=0; `pc_4_out` holds its value.
- Issue condition in FETCH: `redirect`=0 and (`ins_valid`=0 or consume).
  - When met, drive `imem_req`=1 and `imem_addr`=`pc`.
  - At the edge: `req_addr`<=`pc` and `pc`<=`pc`+4 (mod 2^32).
- FETCH transitions:
  - Issue with `imem_ack`=1: zero-wait. Buffer <= {`imem_rdata`, `pc`+4, valid}; stay in FETCH.
  - Issue with no ack: go to WAIT.
  - No issue: `imem_req`=0.
- WAIT:
  - `imem_req`=1 and `imem_addr`=`req_addr`, held stable until ack regardless of `pc_write`.
  - On ack: buffer <= {`imem_rdata`, `req_addr`+4, valid}; go to FETCH.
  - The buffer is always empty when the ack lands, because issue required a free slot.
- Redirect has priority over everything, including `pc_write`=0.
  - At the edge: `pc`<=`redirect_pc` with bits [1:0] cleared; buffer cleared (`ins_valid`=0, `ins_out`=0).
  - No request is issued in the redirect cycle.
  - In WAIT with no ack this cycle: go to DROP.
  - In WAIT with ack this cycle: the data is discarded; go to FETCH.
  - In FETCH: stay in FETCH.
- DROP:
  - Keep `imem_req`=1 and `imem_addr`=`req_addr` until ack, then discard `imem_rdata` and go to FETCH.
  - A further redirect while in DROP only updates `pc`.
- Memory handshake is never withdrawn: once `imem_req` is asserted with an address, it stays asserted with that address until `imem_ack`.

## Timing
- Reset (async assert, sync release) clears the following:
  - `pc`=`RESET_PC`, state=FETCH.
  - `ins_out`=0, `pc_4_out`=0, `ins_valid`=0, `fetch_fault`=0.
  - `req_addr`=0.
  - `imem_req`=0 while `reset`=0.
- First request is the first cycle after reset release, at `imem_addr`=`RESET_PC`.
- Latency: an ack at edge N gives `ins_valid`=1 after edge N; with zero-wait memory and `pc_write`=1, throughput is 1 instruction/cycle.
- An N-wait-state memory gives 1 instruction per N+1 cycles, with `ins_valid`=0 (NOP) in between.
- Reset mid-request abandons the outstanding request; memory must tolerate `imem_req` dropping during reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_fault`=1 (sticky) at the edge and enters FAULT.
  - Any outstanding request completes first; its ack is discarded.
  - In FAULT: `imem_req`=0 and `ins_valid`=0 until reset.
- Not defined: bits [1:0] are silently cleared, `fetch_fault` is constant 0, and there is no FAULT state.

## Test plan
- Reset release with `RESET_PC`=0x00400000, always-ack memory, `pc_write`=1 -> `imem_addr` 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; `ins_valid`=1 from the second cycle; `pc_4_out`=0x00400004, 0x00400008.
- Buffer valid, `pc_write`=0 for 3 cycles -> `ins_out`/`pc_4_out` held, `imem_req`=0, `pc` unchanged; on `pc_write`=1, fetch resumes at the next sequential address.
- Ack delayed 2 cycles for addr 0x00400010 -> `imem_addr` stable 3 cycles, `ins_valid`=0 and `ins_out`=0 meanwhile; then `ins_out`=`rdata` and `pc_4_out`=0x00400014.
- Redirect to 0x00400100 in WAIT for 0x00400020; ack 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF is never presented; next request is at 0x00400100.
- Redirect to 0x00400200 in the same cycle as an ack -> ack data discarded, `ins_valid`=0; the following cycle requests 0x00400200.
- With the macro, redirect to 0x00400102 -> `fetch_fault`=1, `imem_req`=0 thereafter. Without the macro, the same stimulus requests 0x00400100 and `fetch_fault` stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to imem and buffers one instruction for IF/ID.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_out,
    output logic [31:0] pc_4_out,
    output logic        ins_valid,
    output logic        fetch_fault
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] FAULT = 2'd3;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_4_q, pc_4_d;
    logic        valid_q, valid_d;
    logic        consume;
    logic        issue;
    logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;
    logic        bad_redirect;
`endif

    always_comb begin
        consume         = valid_q & pc_write;
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
        // New requests need a free buffer slot; gating with reset keeps imem_req low while reset is held.
        issue    = reset & (state_q == FETCH) & ~redirect & (~valid_q | consume);
        imem_req = issue | (state_q == WAIT) | (state_q == DROP);
        imem_addr = (state_q == FETCH) ? pc_q : req_addr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        bad_redirect = redirect & (redirect_pc[1:0] != 2'b00);
`endif
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ins_d      = ins_q;
        pc_4_d     = pc_4_q;
        valid_d    = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q | bad_redirect;
`endif
        if (consume) begin
            valid_d = 1'b0;
            ins_d   = 32'h0;
        end

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    ins_d   = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (bad_redirect) state_d = FAULT;
`endif
                end else if (issue) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    if (imem_ack) begin
                        ins_d   = imem_rdata;
                        pc_4_d  = pc_q + 32'd4;
                        valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    ins_d   = 32'h0;
                    state_d = imem_ack ? FETCH : DROP;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (bad_redirect && imem_ack) state_d = FAULT;
`endif
                end else if (imem_ack) begin
                    ins_d   = imem_rdata;
                    pc_4_d  = req_addr_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (redirect) pc_d = redirect_target;
                if (imem_ack) begin
                    state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (fault_q || bad_redirect) state_d = FAULT;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            ins_q      <= 32'h0;
            pc_4_q     <= 32'h0;
            valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ins_q      <= ins_d;
            pc_4_q     <= pc_4_d;
            valid_q    <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign ins_out   = ins_q;
    assign pc_4_out  = pc_4_q;
    assign ins_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed start-up/stall/wait/redirect sequences, then random traffic
// scored against the sequential-instruction-stream model.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins_out;
    logic [31:0] pc_4_out;
    logic        ins_valid;
    logic        fetch_fault;

    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_exp;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins_out(ins_out),
        .pc_4_out(pc_4_out), .ins_valid(ins_valid), .fetch_fault(fetch_fault)
    );

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // The stream IF/ID should consume: sequential words from the last reset/redirect target.
    task automatic top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_exp);
            next_exp = next_exp + 32'd4;
        end
    endtask

    task automatic drive(input logic pw, input logic rd, input logic [31:0] rpc, input logic ack_en);
        pc_write    = pw;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = 1'b0;
        if (rd) begin
            exp_q.delete();
            next_exp = rpc & 32'hFFFF_FFFC;
        end
        top_up();
        #1;
        imem_ack   = ack_en & imem_req;
        imem_rdata = imem_req ? mem_word(imem_addr) : 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor/scoreboard: pops an expected entry whenever the buffer is consumed.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev_pend = 1'b0;
            end else begin
                if (ins_valid === 1'b0) chk("nop_when_invalid", ins_out, 32'h0);
                if (prev_pend) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                if (imem_req) chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                if (ins_valid && pc_write && !redirect) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty actual=%h required=none", pc_4_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_ins_out", ins_out, mem_word(e));
                        chk("sb_pc_4_out", pc_4_out, e + 32'd4);
                        consumed++;
                    end
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin
        logic        rd, pw, ak;
        logic [31:0] rpc;
        reset = 1'b0; pc_write = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        next_exp = RPC;
        top_up();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins_out", ins_out, 32'h0);
        chk("rst_pc_4_out", pc_4_out, 32'h0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);

        // Start-up with zero-wait memory
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1, 0, 0, 1);
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RPC);
        chk("first_valid", 32'(ins_valid), 32'd0);
        for (int i = 1; i < 3; i++) begin
            step(); drive(1, 0, 0, 1);
            @(negedge clk);
            chk("seq_addr", imem_addr, RPC + 32'(4 * i));
            chk("seq_valid", 32'(ins_valid), 32'd1);
            chk("seq_pc_4", pc_4_out, RPC + 32'(4 * i));
        end

        // Stall: buffer held, no request
        for (int i = 0; i < 3; i++) begin
            step(); drive(0, 0, 0, 1);
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc_4", pc_4_out, RPC + 32'hC);
            chk("stall_ins", ins_out, mem_word(RPC + 32'h8));
        end
        step(); drive(1, 0, 0, 1);
        @(negedge clk);
        chk("resume_addr", imem_addr, RPC + 32'hC);

        // Two wait states on 0x00400010
        step(); drive(1, 0, 0, 0);
        @(negedge clk);
        chk("wait_addr0", imem_addr, RPC + 32'h10);
        for (int i = 0; i < 2; i++) begin
            step(); drive(1, 0, 0, (i == 1));
            @(negedge clk);
            chk("wait_addr", imem_addr, RPC + 32'h10);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_valid", 32'(ins_valid), 32'd0);
        end
        step(); drive(1, 0, 0, 0);
        @(negedge clk);
        chk("wait_data", ins_out, mem_word(RPC + 32'h10));
        chk("wait_pc_4", pc_4_out, RPC + 32'h14);

        // Redirect while waiting on 0x00400014; its late data must be dropped
        step(); drive(1, 1, 32'h0040_0100, 0);
        step(); drive(1, 0, 0, 0);
        step(); drive(1, 0, 0, 1);
        step(); drive(1, 0, 0, 1);
        @(negedge clk);
        chk("drop_valid", 32'(ins_valid), 32'd0);
        chk("drop_next_addr", imem_addr, 32'h0040_0100);
        chk("drop_next_req", 32'(imem_req), 32'd1);

        // Redirect in the same cycle as an ack
        step(); drive(1, 0, 0, 0);
        step(); drive(1, 1, 32'h0040_0200, 1);
        step(); drive(1, 0, 0, 1);
        @(negedge clk);
        chk("rdack_valid", 32'(ins_valid), 32'd0);
        chk("rdack_addr", imem_addr, 32'h0040_0200);

        // Random traffic, including targets near the top of the address space
        for (int i = 0; i < 3000; i++) begin
            step();
            rd  = ($urandom_range(0, 99) < 6);
            pw  = ($urandom_range(0, 3) != 0);
            ak  = ($urandom_range(0, 9) < 6);
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            drive(pw, rd, rpc, ak);
        end
        @(negedge clk);
        chk("progress", 32'(consumed > 300), 32'd1);

        // Misaligned redirect
        step(); drive(1, 1, 32'h0040_0102, 1);
        step(); drive(1, 0, 0, 1);
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_req", 32'(imem_req), 32'd0);
        step(); drive(1, 0, 0, 1);
        @(negedge clk);
        chk("mis_req_hold", 32'(imem_req), 32'd0);
        chk("mis_valid", 32'(ins_valid), 32'd0);
`else
        chk("mis_fault", 32'(fetch_fault), 32'd0);
        chk("mis_req", 32'(imem_req), 32'd1);
        chk("mis_addr", imem_addr, 32'h0040_0100);
        step(); drive(1, 0, 0, 1);
        @(negedge clk);
        chk("mis_valid", 32'(ins_valid), 32'd1);
        chk("mis_pc_4", pc_4_out, 32'h0040_0104);
`endif
        step(); drive(0, 0, 0, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
